if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have these ports: clk (input, 1): rising-edge clock; all state changes on this edge.
REQ-002 SHALL have: reset_n (input, 1): reset, asynchronous, active-low.
REQ-003 SHALL have: load (input, 1): downstream IF/ID consumer accepts the current output this cycle.
REQ-004 SHALL have: redirect (input, 1) and redirect_pc (input, 16): taken branch/jump/trap with its target PC.
REQ-005 SHALL have: imem_read (output, 1), imem_address (output, 16), imem_resp (input, 1), imem_rdata (input, 16): instruction memory request/response.
REQ-006 SHALL have: ir_out (output, 16), pc_plus2_out (output, 16), valid_out (output, 1): fetched instruction, its PC+2, and slot-valid flag.
REQ-007 SHALL have, only when IF_PERF_COUNT_EN is defined: fetch_count (output, 16) and stall_count (output, 16).

Function
REQ-008 SHALL contain a 16-bit PC, a one-entry output slot (ir/pc_plus2/valid) and a one-entry hold buffer.
REQ-009 SHALL implement the FSM states FETCH, HOLD and DRAIN.
REQ-010 In FETCH, imem_read SHALL be 1 and imem_address SHALL equal the PC.
REQ-011 In HOLD, imem_read SHALL be 0.
REQ-012 The slot SHALL be writable this cycle when valid_out=0 or load=1.
REQ-013 On FETCH with imem_resp=1 and the slot writable: ir_out<=imem_rdata, pc_plus2_out<=PC+2, valid_out<=1, PC<=PC+2; the FSM SHALL stay in FETCH.
REQ-014 On FETCH with imem_resp=1 and the slot not writable: the hold buffer SHALL take imem_rdata and PC+2, PC<=PC+2, and the FSM SHALL go to HOLD.
REQ-015 In HOLD with load=1: the slot SHALL take the hold-buffer contents with valid_out=1, and the FSM SHALL go to FETCH.
REQ-016 In HOLD with load=0: all state SHALL be unchanged.
REQ-017 When load=1 and nothing is written into the slot that cycle, valid_out SHALL go to 0; ir_out and pc_plus2_out SHALL keep their values.
REQ-018 Latency: data from a response SHALL be visible on ir_out the cycle after imem_resp, when the slot is writable.
REQ-019 PC arithmetic SHALL be 16-bit modulo; 0xFFFE+2 SHALL give 0x0000.
REQ-020 redirect SHALL have priority over every other event in the same cycle.
REQ-021 On redirect: PC<=redirect_pc, valid_out<=0, the hold buffer SHALL be discarded, and load that cycle SHALL be ignored.
REQ-022 On redirect in FETCH with imem_resp=0, the FSM SHALL go to DRAIN; otherwise it SHALL go to FETCH.
REQ-023 In DRAIN: imem_read SHALL be 1 with imem_address held at the pre-redirect address; on imem_resp=1 the data SHALL be discarded and the FSM SHALL go to FETCH.
REQ-024 A further redirect during DRAIN SHALL update the PC and the FSM SHALL remain in DRAIN.
REQ-025 A response in the redirect cycle SHALL be discarded.
REQ-026 redirect_pc bit 0 SHALL be ignored (forced to 0).

Reset
REQ-027 While reset_n=0: PC=0x0000, FSM=FETCH, valid_out=0, ir_out=0, pc_plus2_out=0, hold buffer cleared, imem_read=0.
REQ-028 When IF_PERF_COUNT_EN is defined, both counters SHALL be 0 while reset_n=0.
REQ-029 The first request (address 0x0000) SHALL be issued in the first cycle after reset_n rises.
REQ-030 Reset asserted mid-request or mid-DRAIN SHALL abandon the transaction immediately, with no pending state retained.

Configuration
REQ-031 Macro IF_PERF_COUNT_EN defined: fetch_count SHALL increment on every instruction written to the slot or the hold buffer.
REQ-032 Macro IF_PERF_COUNT_EN defined: stall_count SHALL increment on every cycle in HOLD.
REQ-033 Both counters SHALL saturate at 0xFFFF.
REQ-034 Macro IF_PERF_COUNT_EN undefined: the counters and their ports SHALL be absent, with identical fetch behaviour.

Verification
REQ-035 Reset release, 1-cycle memory, load=1 constantly -> addresses 0x0000, 0x0002, 0x0004; pc_plus2_out 0x0002, 0x0004, 0x0006 on consecutive cycles; valid_out=1 from cycle 2.
REQ-036 load=0 with slot full, resp for 0x0004 (rdata 0x1234) -> HOLD, imem_read=0; load=1 three cycles later -> ir_out=0x1234, pc_plus2_out=0x0006, next address 0x0006.
REQ-037 Redirect to 0x3001 while the 0x0008 request is outstanding (resp 2 cycles later) -> valid_out=0 next cycle, address held at 0x0008 until resp, that data discarded, next address 0x3000.
REQ-038 Redirect to 0x0400 coincident with imem_resp and load=1 -> response dropped, valid_out=0, next address 0x0400.
REQ-039 PC=0xFFFE fetch completes -> pc_plus2_out=0x0000, next address 0x0000.
REQ-040 With IF_PERF_COUNT_EN: 5 fetches plus 3 HOLD cycles -> fetch_count=5, stall_count=3; reset_n pulse low mid-HOLD -> all outputs zero, imem_read=0 asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: 16-bit PC, one-entry output slot, and a one-entry hold buffer for a response the consumer cannot yet take.
// Define IF_PERF_COUNT_EN to add saturating fetch_count / stall_count outputs.
module if_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_ir_q, hold_ir_d;
    logic [15:0] hold_pc2_q, hold_pc2_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic        slot_writable;
    logic [15:0] pc_inc;

    assign slot_writable = !valid_q || load;
    assign pc_inc        = pc_q + 16'd2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pc_q         <= 16'h0000;
            ir_q         <= 16'h0000;
            pc2_q        <= 16'h0000;
            valid_q      <= 1'b0;
            hold_ir_q    <= 16'h0000;
            hold_pc2_q   <= 16'h0000;
            drain_addr_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pc2_q        <= pc2_d;
            valid_q      <= valid_d;
            hold_ir_q    <= hold_ir_d;
            hold_pc2_q   <= hold_pc2_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Redirect overrides everything; a request still in flight is drained with its address held stable.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pc2_d        = pc2_q;
        valid_d      = valid_q;
        hold_ir_d    = hold_ir_q;
        hold_pc2_d   = hold_pc2_q;
        drain_addr_d = drain_addr_q;

        if (redirect) begin
            pc_d       = {redirect_pc[15:1], 1'b0};
            valid_d    = 1'b0;
            hold_ir_d  = 16'h0000;
            hold_pc2_d = 16'h0000;
            case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        state_d = FETCH;
                    end else begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                DRAIN:   state_d = imem_resp ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        pc_d = pc_inc;
                        if (slot_writable) begin
                            ir_d    = imem_rdata;
                            pc2_d   = pc_inc;
                            valid_d = 1'b1;
                        end else begin
                            hold_ir_d  = imem_rdata;
                            hold_pc2_d = pc_inc;
                            state_d    = HOLD;
                        end
                    end else if (load) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (load) begin
                        ir_d    = hold_ir_q;
                        pc2_d   = hold_pc2_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (load) valid_d = 1'b0;
                    if (imem_resp) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign imem_read    = reset_n && (state_q != HOLD);
    assign imem_address = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign ir_out       = ir_q;
    assign pc_plus2_out = pc2_q;
    assign valid_out    = valid_q;

`ifdef IF_PERF_COUNT_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;
    logic        fetch_event;

    // Every accepted response counts once, whether it lands in the slot or the hold buffer.
    assign fetch_event = (state_q == FETCH) && imem_resp && !redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (fetch_event && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (state_q == HOLD && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
